// File: rtl/ttt_pkg.sv
// ttt_pkg: shared types, encodings and win-line table for the tic-tac-toe sequencer
package ttt_pkg;
  localparam int NUM_CELLS = 9;
  typedef enum logic [1:0] {EMPTY = 2'b00, P1 = 2'b01, P2 = 2'b10} cell_t;
  typedef enum logic [2:0] {IDLE = 3'd0, WAIT_P1 = 3'd1, WAIT_P2 = 3'd2, EVAL = 3'd3, DONE = 3'd4} state_t;
  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1 = 2'b01;
  localparam logic [1:0] WIN_P2 = 2'b10;
  localparam logic [3:0] WIN_LINES [8][3] = '{
    '{4'd0, 4'd1, 4'd2}, '{4'd3, 4'd4, 4'd5}, '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6}, '{4'd1, 4'd4, 4'd7}, '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8}, '{4'd2, 4'd4, 4'd6}
  };
  // out-of-range indices read as EMPTY so callers never slice past the board
  function automatic cell_t cell_at(input logic [17:0] b, input logic [3:0] c);
    cell_t r;
    r = EMPTY;
    for (int i = 0; i < NUM_CELLS; i++)
      if (c == 4'(i)) r = cell_t'(b[2*i +: 2]);
    return r;
  endfunction
endpackage

// File: rtl/win_detect.sv
// win_detect: combinational line/full check of the packed board
module win_detect
  import ttt_pkg::*;
(
  input  logic [17:0] i_board,
  output logic        o_p1_win,
  output logic        o_p2_win,
  output logic        o_full
);
  // scan all eight lines and every cell for emptiness
  always_comb begin
    o_p1_win = 1'b0;
    o_p2_win = 1'b0;
    o_full = 1'b1;
    for (int l = 0; l < 8; l++) begin
      o_p1_win |= (cell_at(i_board, WIN_LINES[l][0]) == P1) && (cell_at(i_board, WIN_LINES[l][1]) == P1) && (cell_at(i_board, WIN_LINES[l][2]) == P1);
      o_p2_win |= (cell_at(i_board, WIN_LINES[l][0]) == P2) && (cell_at(i_board, WIN_LINES[l][1]) == P2) && (cell_at(i_board, WIN_LINES[l][2]) == P2);
    end
    for (int c = 0; c < NUM_CELLS; c++)
      if (i_board[2*c +: 2] == EMPTY) o_full = 1'b0;
  end
endmodule

// File: rtl/turn_arbiter.sv
// turn_arbiter: turn-ordered move arbitration, board ownership and win/draw sequencing (optional TURN_TIMEOUT_EN forfeit timer)
module turn_arbiter
  import ttt_pkg::*;
`ifdef TURN_TIMEOUT_EN
#(
  parameter int TIMEOUT_CYCLES = 255
)
`endif
(
  input  logic        ph1,
  input  logic        ph2,
  input  logic        reset,
  input  logic        start,
  input  logic        isPlayer1Start,
  input  logic        p1_req,
  input  logic [3:0]  p1_cell,
  input  logic        p2_req,
  input  logic [3:0]  p2_cell,
  output logic        p1_ack,
  output logic        p2_ack,
  output logic        p1_nack,
  output logic        p2_nack,
  output logic [17:0] gBoard,
  output logic [2:0]  outputState,
  output logic        gameIsDone,
  output logic [1:0]  winner
);
  logic        r_rst_n, r_start, r_p1s, r_p1_req, r_p2_req;
  logic [3:0]  r_p1_cell, r_p2_cell;
  state_t      r_state;
  logic [17:0] r_board;
  logic [3:0]  r_cnt;
  logic [1:0]  r_winner;
  logic        r_last_p1;
  logic        r_p1_ack, r_p1_nack, r_p2_ack, r_p2_nack;
  logic        w_p1_turn, w_req, w_legal, w_p1_win, w_p2_win, w_full;
  logic [3:0]  w_cell;
  cell_t       w_code;
`ifdef TURN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tcnt;
`endif
  assign w_p1_turn = (r_state == WAIT_P1);
  assign w_req = w_p1_turn ? r_p1_req : r_p2_req;
  assign w_cell = w_p1_turn ? r_p1_cell : r_p2_cell;
  assign w_code = w_p1_turn ? P1 : P2;
  assign w_legal = (w_cell <= 4'd8) && (cell_at(r_board, w_cell) == EMPTY);
  win_detect u_win (
    .i_board  (r_board),
    .o_p1_win (w_p1_win),
    .o_p2_win (w_p2_win),
    .o_full   (w_full)
  );
  // master stage: snapshot inputs on phase 1 so phase 2 acts on stable values
  always_ff @(posedge ph1) begin
    r_rst_n <= reset;
    r_start <= start;
    r_p1s <= isPlayer1Start;
    r_p1_req <= p1_req;
    r_p1_cell <= p1_cell;
    r_p2_req <= p2_req;
    r_p2_cell <= p2_cell;
  end
  // slave stage: game FSM with registered pulses, board and winner
  always_ff @(posedge ph2) begin
    r_p1_ack <= 1'b0;
    r_p1_nack <= 1'b0;
    r_p2_ack <= 1'b0;
    r_p2_nack <= 1'b0;
    if (!r_rst_n) begin
      r_state <= IDLE;
      r_board <= '0;
      r_cnt <= '0;
      r_winner <= WIN_NONE;
      r_last_p1 <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: if (r_start) begin
          r_board <= '0;
          r_cnt <= '0;
          r_winner <= WIN_NONE;
          r_state <= r_p1s ? WAIT_P1 : WAIT_P2;
`ifdef TURN_TIMEOUT_EN
          r_tcnt <= '0;
`endif
        end
        WAIT_P1, WAIT_P2: if (w_req && w_legal) begin
          for (int i = 0; i < NUM_CELLS; i++)
            if (w_cell == 4'(i)) r_board[2*i +: 2] <= w_code;
          r_cnt <= (r_cnt == 4'd9) ? r_cnt : r_cnt + 4'd1;
          r_last_p1 <= w_p1_turn;
          r_p1_ack <= w_p1_turn;
          r_p2_ack <= !w_p1_turn;
          r_state <= EVAL;
        end else begin
`ifdef TURN_TIMEOUT_EN
          if (r_tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            r_winner <= w_p1_turn ? WIN_P2 : WIN_P1;
            r_state <= DONE;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
            r_p1_nack <= w_req && w_p1_turn;
            r_p2_nack <= w_req && !w_p1_turn;
          end
`else
          r_p1_nack <= w_req && w_p1_turn;
          r_p2_nack <= w_req && !w_p1_turn;
`endif
        end
        EVAL: begin
          if (w_p1_win) begin
            r_winner <= WIN_P1;
            r_state <= DONE;
          end else if (w_p2_win) begin
            r_winner <= WIN_P2;
            r_state <= DONE;
          end else if (r_cnt == 4'd9 || w_full) begin
            r_winner <= WIN_NONE;
            r_state <= DONE;
          end else begin
            r_state <= r_last_p1 ? WAIT_P2 : WAIT_P1;
`ifdef TURN_TIMEOUT_EN
            r_tcnt <= '0;
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign p1_ack = r_p1_ack;
  assign p2_ack = r_p2_ack;
  assign p1_nack = r_p1_nack;
  assign p2_nack = r_p2_nack;
  assign gBoard = r_board;
  assign outputState = r_state;
  assign gameIsDone = (r_state == DONE);
  assign winner = r_winner;
endmodule
